jstk_txn_scheduler: RTL and testbench

Sequences every SPI transaction to the PmodJSTK interface: periodic position polls, plus on-demand LED command updates from a requester. Every transaction carries the current LED state, so LEDs persist across polls. Captures the 40-bit reply, unpacks X/Y/buttons and raises a one-cycle valid strobe. Replaces the free-running 10 Hz sndRec divider between the top level and the PmodJSTK interface.

---
 rtl/jstk_pkg.sv | 52 +++++
 rtl/jstk_poll_timer.sv | 34 +++
 rtl/jstk_txn_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_jstk_txn_scheduler.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jstk_pkg.sv
// Shared definitions for the PmodJSTK transaction scheduler.
//   state_e          : scheduler FSM states
//   FRAME_W          : width of one SPI frame in either direction
//   LED_CMD_PREFIX   : command bits placed above the LED field in every frame
//   *_MSB / *_LSB    : where X, Y and button fields sit in the reply frame
//   TMO_W            : width of the shared state-duration counter
//   unpack_*         : field extraction from a reply frame
//   sat_inc          : saturating increment for the duration counter
package jstk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_XFER    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_GAP     = 3'd4
    } state_e;

    localparam int FRAME_W = 40;
    localparam int TMO_W   = 17;

    localparam logic [5:0] LED_CMD_PREFIX = 6'b100000;

    localparam int X_LO_MSB = 23;
    localparam int X_LO_LSB = 16;
    localparam int X_HI_MSB = 9;
    localparam int X_HI_LSB = 8;
    localparam int Y_LO_MSB = 39;
    localparam int Y_LO_LSB = 32;
    localparam int Y_HI_MSB = 25;
    localparam int Y_HI_LSB = 24;
    localparam int BTN_MSB  = 2;
    localparam int BTN_LSB  = 0;

    function automatic logic [9:0] unpack_x(input logic [FRAME_W-1:0] f);
        return {f[X_HI_MSB:X_HI_LSB], f[X_LO_MSB:X_LO_LSB]};
    endfunction

    function automatic logic [9:0] unpack_y(input logic [FRAME_W-1:0] f);
        return {f[Y_HI_MSB:Y_HI_LSB], f[Y_LO_MSB:Y_LO_LSB]};
    endfunction

    function automatic logic [2:0] unpack_btn(input logic [FRAME_W-1:0] f);
        return f[BTN_MSB:BTN_LSB];
    endfunction

    function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v,
                                                 input logic [TMO_W-1:0] lim);
        return (v < lim) ? v + TMO_W'(1) : v;
    endfunction

endpackage

// File: rtl/jstk_poll_timer.sv
// Free-running wrap counter that paces position polls.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset, counter returns to 0
//   tick_o  : high for the one cycle in which the counter wraps
// The count runs 0..PERIOD-1 and never stops; the consumer owns any
// pending-request bookkeeping.
module jstk_poll_timer #(
    parameter int unsigned PERIOD = 1200000
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/jstk_txn_scheduler.sv
// Scheduler for every SPI transaction sent to the PmodJSTK interface.
// Launches periodic position polls and on-demand LED updates, waits for the
// interface to run the transfer, unpacks the reply and strobes data_valid.
//   clk_i           : system clock
//   rst_ni          : asynchronous active-low reset
//   led_req_i       : LED update request, held until led_ack_o
//   led_val_i       : requested LED state {LED2,LED1}
//   led_ack_o       : one-cycle acceptance pulse
//   jstk_snd_rec_o  : start request to the PmodJSTK interface
//   jstk_din_o      : frame sent to the joystick (always carries LED state)
//   jstk_ss_i       : slave select from the interface, low while transferring
//   jstk_dout_i     : reply frame from the interface
//   xpos_o, ypos_o  : joystick position, 0..1023
//   buttons_o       : {trigger, btn1, btn0}
//   data_valid_o    : one-cycle pulse when a new sample is latched
//   busy_o          : high whenever the FSM is not idle
//   timeout_err_o   : sticky timeout flag, cleared only by reset
//
// state   | meaning
// IDLE    | waiting for a pending LED command or poll
// START   | jstk_snd_rec high, waiting for SS to fall
// XFER    | SS low, waiting for the transfer to finish
// CAPTURE | latch reply fields, pulse data_valid
// GAP     | enforced idle time before the next transaction
module jstk_txn_scheduler
    import jstk_pkg::*;
#(
    parameter int unsigned POLL_CYCLES   = 1200000,
    parameter int unsigned START_TIMEOUT = 4096,
    parameter int unsigned XFER_TIMEOUT  = 65536,
    parameter int unsigned GAP_CYCLES    = 120
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               led_req_i,
    input  logic [1:0]         led_val_i,
    output logic               led_ack_o,
    output logic               jstk_snd_rec_o,
    output logic [FRAME_W-1:0] jstk_din_o,
    input  logic               jstk_ss_i,
    input  logic [FRAME_W-1:0] jstk_dout_i,
    output logic [9:0]         xpos_o,
    output logic [9:0]         ypos_o,
    output logic [2:0]         buttons_o,
    output logic               data_valid_o,
    output logic               busy_o,
    output logic               timeout_err_o
);

    localparam logic [TMO_W-1:0] START_LIM = TMO_W'(START_TIMEOUT);
    localparam logic [TMO_W-1:0] XFER_LIM  = TMO_W'(XFER_TIMEOUT);
    localparam logic [TMO_W-1:0] GAP_LIM   = TMO_W'(GAP_CYCLES);

    state_e           state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic [1:0]       led_state_q, led_state_d;
    logic             poll_pend_q, poll_pend_d;
    logic             cmd_pend_q, cmd_pend_d;
    logic             led_ack_q, led_ack_d;
    logic             dv_q, dv_d;
    logic             err_q, err_d;
    logic [9:0]       xpos_q, xpos_d;
    logic [9:0]       ypos_q, ypos_d;
    logic [2:0]       btn_q, btn_d;
    logic             poll_tick;
    logic             launch;

    // Reply bits outside the X/Y/button fields carry nothing we use.
    logic dout_unused;
    assign dout_unused = ^{jstk_dout_i[31:26], jstk_dout_i[15:10], jstk_dout_i[7:3]};

    jstk_poll_timer #(
        .PERIOD(POLL_CYCLES)
    ) u_poll_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .tick_o (poll_tick)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        led_state_d = led_state_q;
        poll_pend_d = poll_pend_q | poll_tick;
        cmd_pend_d  = cmd_pend_q;
        led_ack_d   = 1'b0;
        dv_d        = 1'b0;
        err_d       = err_q;
        xpos_d      = xpos_q;
        ypos_d      = ypos_q;
        btn_d       = btn_q;
        launch      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A just-accepted command launches first; a fresh request is
                // accepted before a poll so the poll rides on the new LED frame.
                if (cmd_pend_q) begin
                    launch = 1'b1;
                end else if (led_req_i) begin
                    led_ack_d   = 1'b1;
                    led_state_d = led_val_i;
                    cmd_pend_d  = 1'b1;
                end else if (poll_pend_q || poll_tick) begin
                    launch = 1'b1;
                end
            end
            ST_START: begin
                if (!jstk_ss_i) begin
                    state_d = ST_XFER;
                end else if (cnt_q >= START_LIM - TMO_W'(1)) begin
                    err_d   = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = sat_inc(cnt_q, START_LIM);
                end
            end
            ST_XFER: begin
                if (jstk_ss_i) begin
                    state_d = ST_CAPTURE;
                end else if (cnt_q >= XFER_LIM - TMO_W'(1)) begin
                    err_d   = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = sat_inc(cnt_q, XFER_LIM);
                end
            end
            ST_CAPTURE: begin
                xpos_d  = unpack_x(jstk_dout_i);
                ypos_d  = unpack_y(jstk_dout_i);
                btn_d   = unpack_btn(jstk_dout_i);
                dv_d    = 1'b1;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q >= GAP_LIM - TMO_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = sat_inc(cnt_q, GAP_LIM);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every transaction returns a position sample, so one launch
        // satisfies both kinds of pending work.
        if (launch) begin
            state_d     = ST_START;
            poll_pend_d = 1'b0;
            cmd_pend_d  = 1'b0;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            led_state_q <= 2'b00;
            poll_pend_q <= 1'b0;
            cmd_pend_q  <= 1'b0;
            led_ack_q   <= 1'b0;
            dv_q        <= 1'b0;
            err_q       <= 1'b0;
            xpos_q      <= '0;
            ypos_q      <= '0;
            btn_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            led_state_q <= led_state_d;
            poll_pend_q <= poll_pend_d;
            cmd_pend_q  <= cmd_pend_d;
            led_ack_q   <= led_ack_d;
            dv_q        <= dv_d;
            err_q       <= err_d;
            xpos_q      <= xpos_d;
            ypos_q      <= ypos_d;
            btn_q       <= btn_d;
        end
    end

    assign led_ack_o      = led_ack_q;
    assign jstk_snd_rec_o = (state_q == ST_START);
    assign jstk_din_o     = {LED_CMD_PREFIX, led_state_q, 32'h0};
    assign xpos_o         = xpos_q;
    assign ypos_o         = ypos_q;
    assign buttons_o      = btn_q;
    assign data_valid_o   = dv_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign timeout_err_o  = err_q;

endmodule

// File: tb/tb_jstk_txn_scheduler.sv
// Self-checking bench for jstk_txn_scheduler with a behavioural PmodJSTK
// interface model and an arithmetic model of the reply unpacking.
module tb_jstk_txn_scheduler;

    localparam int POLL = 1000;
    localparam int STO  = 4096;
    localparam int XTO  = 3000;
    localparam int GAPC = 120;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        led_req = 1'b0;
    logic [1:0]  led_val = 2'b00;
    logic        ss      = 1'b1;
    logic [39:0] dout    = 40'h0;
    logic        led_ack, snd_rec, dv, busy, err;
    logic [39:0] din;
    logic [9:0]  xpos, ypos;
    logic [2:0]  buttons;

    always #5 clk = ~clk;

    jstk_txn_scheduler #(
        .POLL_CYCLES   (POLL),
        .START_TIMEOUT (STO),
        .XFER_TIMEOUT  (XTO),
        .GAP_CYCLES    (GAPC)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .led_req_i      (led_req),
        .led_val_i      (led_val),
        .led_ack_o      (led_ack),
        .jstk_snd_rec_o (snd_rec),
        .jstk_din_o     (din),
        .jstk_ss_i      (ss),
        .jstk_dout_i    (dout),
        .xpos_o         (xpos),
        .ypos_o         (ypos),
        .buttons_o      (buttons),
        .data_valid_o   (dv),
        .busy_o         (busy),
        .timeout_err_o  (err)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    logic [1:0] exp_led = 2'b00;

    // Clock edges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // PmodJSTK interface model: sees the start request, pulls SS low for
    // low_len cycles with a reply frame on dout, then releases SS.
    int          low_len    = 500;
    bit          hang       = 1'b0;
    bit          use_fixed  = 1'b0;
    logic [39:0] fixed_dout = 40'h0;
    logic [39:0] txn_dout   = 40'h0;

    always begin
        @(negedge clk);
        if (rst_n && snd_rec && ss && !hang) begin
            @(posedge clk);
            #1;
            txn_dout = use_fixed ? fixed_dout : {8'($urandom), 32'($urandom)};
            dout = txn_dout;
            ss   = 1'b0;
            for (int i = 0; i < low_len; i++) begin
                @(posedge clk);
                if (!rst_n) break;
            end
            #1;
            ss = 1'b1;
        end
    end

    // Event monitors: launch, data_valid and ack timestamps.
    int          n_launch = 0, last_launch = -1;
    int          n_dv = 0, last_dv = -1;
    int          n_ack = 0, last_ack = -1;
    logic [39:0] last_din = 40'h0;
    bit          snd_prev = 1'b0;

    always @(negedge clk) begin
        if (snd_rec && !snd_prev) begin
            n_launch++;
            last_launch = cyc;
            last_din    = din;
        end
        snd_prev = snd_rec;
        if (dv) begin
            n_dv++;
            last_dv = cyc;
        end
        if (led_ack) begin
            n_ack++;
            last_ack = cyc;
        end
    end

    function automatic int model_x(input logic [39:0] d);
        return int'((d >> 8) % 4) * 256 + int'((d >> 16) % 256);
    endfunction

    function automatic int model_y(input logic [39:0] d);
        return int'((d >> 24) % 4) * 256 + int'((d >> 32) % 256);
    endfunction

    function automatic int model_btn(input logic [39:0] d);
        return int'(d % 8);
    endfunction

    function automatic logic [39:0] model_din(input logic [1:0] led);
        return 40'h80_0000_0000 + (40'(led) << 32);
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        led_req = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({led_ack, snd_rec, dv, busy, err} !== 5'b0) begin
            n_mis++;
            $display("FAIL reset_ctrl: got %b want 00000", {led_ack, snd_rec, dv, busy, err});
        end
        n_cmp++;
        if ({xpos, ypos, buttons} !== 23'h0) begin
            n_mis++;
            $display("FAIL reset_data: got x=%h y=%h b=%b want 0", xpos, ypos, buttons);
        end
        n_cmp++;
        if (din !== model_din(2'b00)) begin
            n_mis++;
            $display("FAIL reset_din: got %h want %h", din, model_din(2'b00));
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_poll();
        int d0;
        use_fixed  = 1'b1;
        fixed_dout = 40'hA5_02_3C_01_07;
        low_len    = 500;
        for (int i = 0; i < POLL + 20 && n_launch == 0; i++) step();
        n_cmp++;
        if (n_launch != 1 || last_launch != POLL) begin
            n_mis++;
            $display("FAIL first_launch: got count=%0d cyc=%0d want 1 at %0d", n_launch, last_launch, POLL);
        end
        n_cmp++;
        if (last_din !== model_din(2'b00)) begin
            n_mis++;
            $display("FAIL first_din: got %h want %h", last_din, model_din(2'b00));
        end
        d0 = n_dv;
        for (int i = 0; i < 2000 && n_dv == d0; i++) step();
        n_cmp++;
        if (n_dv != d0 + 1 || last_dv - last_launch != 503) begin
            n_mis++;
            $display("FAIL first_latency: got count=%0d lat=%0d want 1 and 503", n_dv - d0, last_dv - last_launch);
        end
        n_cmp++;
        if (xpos !== 10'h13C || ypos !== 10'h2A5 || buttons !== 3'b111) begin
            n_mis++;
            $display("FAIL unpack_fixed: got x=%h y=%h b=%b want 13c 2a5 111", xpos, ypos, buttons);
        end
        step();
        n_cmp++;
        if (dv !== 1'b0) begin
            n_mis++;
            $display("FAIL dv_width: got %b want 0 one cycle after pulse", dv);
        end
        use_fixed = 1'b0;
    endtask

    task automatic test_random_polls();
        int l0, d0, px, py, pb;
        for (int t = 0; t < 4; t++) begin
            px = int'(xpos); py = int'(ypos); pb = int'(buttons);
            low_len = int'($urandom_range(20, 400));
            l0 = n_launch;
            for (int i = 0; i < 2 * POLL && n_launch == l0; i++) step();
            n_cmp++;
            if (n_launch != l0 + 1 || (last_launch % POLL) != 0) begin
                n_mis++;
                $display("FAIL rnd_launch: got count=%0d cyc=%0d want 1 at multiple of %0d", n_launch - l0, last_launch, POLL);
            end
            n_cmp++;
            if (int'(xpos) != px || int'(ypos) != py || int'(buttons) != pb) begin
                n_mis++;
                $display("FAIL rnd_hold: got x=%h y=%h b=%h want %h %h %h", xpos, ypos, buttons, px, py, pb);
            end
            d0 = n_dv;
            for (int i = 0; i < XTO && n_dv == d0; i++) step();
            n_cmp++;
            if (n_dv != d0 + 1 || last_dv - last_launch != low_len + 3) begin
                n_mis++;
                $display("FAIL rnd_latency: got count=%0d lat=%0d want 1 and %0d", n_dv - d0, last_dv - last_launch, low_len + 3);
            end
            n_cmp++;
            if (int'(xpos) != model_x(txn_dout) || int'(ypos) != model_y(txn_dout) ||
                int'(buttons) != model_btn(txn_dout)) begin
                n_mis++;
                $display("FAIL rnd_unpack: got x=%h y=%h b=%h want %h %h %h", xpos, ypos, buttons,
                         model_x(txn_dout), model_y(txn_dout), model_btn(txn_dout));
            end
        end
    endtask

    task automatic test_led_during_xfer();
        int l0, a0, d0;
        low_len = 300;
        l0 = n_launch;
        for (int i = 0; i < 2 * POLL && n_launch == l0; i++) step();
        for (int i = 0; i < 10 && ss; i++) step();
        led_req = 1'b1;
        led_val = 2'b10;
        a0 = n_ack;
        d0 = n_dv;
        for (int i = 0; i < 2000 && n_ack == a0; i++) step();
        n_cmp++;
        if (n_ack != a0 + 1 || n_dv != d0 + 1) begin
            n_mis++;
            $display("FAIL led_ack_count: got ack=%0d dv=%0d want 1 1", n_ack - a0, n_dv - d0);
        end
        n_cmp++;
        if (last_ack != last_dv + GAPC + 1) begin
            n_mis++;
            $display("FAIL led_ack_time: got %0d want %0d", last_ack, last_dv + GAPC + 1);
        end
        n_cmp++;
        if (din[39:32] !== 8'h82 || busy !== 1'b0) begin
            n_mis++;
            $display("FAIL led_din: got din=%h busy=%b want 82 idle", din[39:32], busy);
        end
        led_req = 1'b0;
        exp_led = 2'b10;
        step();
        n_cmp++;
        if (snd_rec !== 1'b1 || last_launch != last_ack + 1 || led_ack !== 1'b0) begin
            n_mis++;
            $display("FAIL led_launch: got snd=%b at %0d ack=%b want 1 at %0d ack 0", snd_rec, last_launch, led_ack, last_ack + 1);
        end
        d0 = n_dv;
        for (int i = 0; i < XTO && n_dv == d0; i++) step();
        n_cmp++;
        if (n_dv != d0 + 1 || int'(xpos) != model_x(txn_dout) || last_din !== model_din(exp_led)) begin
            n_mis++;
            $display("FAIL led_txn: got dv=%0d x=%h din=%h want 1 %h %h", n_dv - d0, xpos, last_din,
                     model_x(txn_dout), model_din(exp_led));
        end
    endtask

    task automatic test_same_cycle();
        int n_tgt, l0, idle_run;
        low_len  = 100;
        idle_run = 0;
        for (int i = 0; i < 3 * POLL && idle_run < 2; i++) begin
            step();
            idle_run = busy ? 0 : idle_run + 1;
        end
        n_tgt = ((cyc + 2) / POLL + 1) * POLL;
        while (cyc < n_tgt - 1) step();
        led_req = 1'b1;
        led_val = 2'b01;
        l0 = n_launch;
        step();
        n_cmp++;
        if (led_ack !== 1'b1) begin
            n_mis++;
            $display("FAIL same_ack: got %b want 1 at cyc %0d", led_ack, cyc);
        end
        led_req = 1'b0;
        exp_led = 2'b01;
        step();
        n_cmp++;
        if (snd_rec !== 1'b1 || last_launch != n_tgt + 1 || last_din !== model_din(exp_led)) begin
            n_mis++;
            $display("FAIL same_launch: got snd=%b cyc=%0d din=%h want 1 %0d %h", snd_rec, last_launch, last_din,
                     n_tgt + 1, model_din(exp_led));
        end
        while (cyc < n_tgt + POLL - 1) step();
        n_cmp++;
        if (n_launch != l0 + 1) begin
            n_mis++;
            $display("FAIL same_single: got %0d launches want 1", n_launch - l0);
        end
        step();
        n_cmp++;
        if (n_launch != l0 + 2 || last_launch != n_tgt + POLL) begin
            n_mis++;
            $display("FAIL same_next_poll: got count=%0d cyc=%0d want 2 at %0d", n_launch - l0, last_launch, n_tgt + POLL);
        end
    endtask

    task automatic test_timeout();
        int l0, d0, s, f;
        for (int i = 0; i < 2 * POLL && busy; i++) step();
        hang = 1'b1;
        d0 = n_dv;
        l0 = n_launch;
        for (int i = 0; i < 2 * POLL && n_launch == l0; i++) step();
        s = last_launch;
        n_cmp++;
        if (err !== 1'b0) begin
            n_mis++;
            $display("FAIL tmo_early: got err=%b want 0 at launch", err);
        end
        for (int i = 0; i < STO + 20 && snd_rec === 1'b1; i++) step();
        f = cyc;
        n_cmp++;
        if (f - s != STO || err !== 1'b1) begin
            n_mis++;
            $display("FAIL tmo_start: got dur=%0d err=%b want %0d 1", f - s, err, STO);
        end
        hang = 1'b0;
        for (int i = 0; i < GAPC + 20 && busy; i++) step();
        l0 = n_launch;
        for (int i = 0; i < 2 * POLL && n_launch == l0; i++) step();
        for (int i = 0; i < XTO && n_dv == d0; i++) step();
        n_cmp++;
        if (n_launch != l0 + 1 || n_dv != d0 + 1 || err !== 1'b1 || int'(ypos) != model_y(txn_dout)) begin
            n_mis++;
            $display("FAIL tmo_recover: got launch=%0d dv=%0d err=%b y=%h want 1 1 1 %h", n_launch - l0, n_dv - d0,
                     err, ypos, model_y(txn_dout));
        end
    endtask

    task automatic test_reset_mid_xfer();
        int l0, d0;
        low_len = 400;
        l0 = n_launch;
        for (int i = 0; i < 2 * POLL && n_launch == l0; i++) step();
        for (int i = 0; i < 10 && ss; i++) step();
        repeat (5) step();
        d0 = n_dv;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({led_ack, snd_rec, dv, busy, err} !== 5'b0) begin
            n_mis++;
            $display("FAIL midrst_ctrl: got %b want 00000", {led_ack, snd_rec, dv, busy, err});
        end
        n_cmp++;
        if ({xpos, ypos, buttons} !== 23'h0 || din !== model_din(2'b00)) begin
            n_mis++;
            $display("FAIL midrst_data: got x=%h y=%h b=%b din=%h want 0 and %h", xpos, ypos, buttons, din,
                     model_din(2'b00));
        end
        step();
        step();
        rst_n = 1'b1;
        exp_led = 2'b00;
        l0 = n_launch;
        for (int i = 0; i < POLL + 20 && n_launch == l0; i++) step();
        n_cmp++;
        if (n_launch != l0 + 1 || last_launch != POLL || n_dv != d0) begin
            n_mis++;
            $display("FAIL midrst_relaunch: got count=%0d cyc=%0d dv=%0d want 1 %0d 0", n_launch - l0, last_launch,
                     n_dv - d0, POLL);
        end
        for (int i = 0; i < XTO && n_dv == d0; i++) step();
        n_cmp++;
        if (n_dv != d0 + 1 || last_dv - last_launch != low_len + 3 || int'(buttons) != model_btn(txn_dout)) begin
            n_mis++;
            $display("FAIL midrst_txn: got dv=%0d lat=%0d b=%h want 1 %0d %h", n_dv - d0, last_dv - last_launch,
                     buttons, low_len + 3, model_btn(txn_dout));
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_poll();
        test_random_polls();
        test_led_during_xfer();
        test_same_cycle();
        test_timeout();
        test_reset_mid_xfer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
